// File: rtl/ms_pkg.sv
// Shared definitions for the master switch: FSM state encoding and the
// arbitration-mode constants used by the ARB_MODE parameter.
package ms_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FIND = 3'd2,
    ST_WAIT = 3'd3,
    ST_RUN  = 3'd4
  } ms_state_e;

  localparam int unsigned ARB_RR    = 0;  // round-robin from the rotating pointer
  localparam int unsigned ARB_FIXED = 1;  // lowest eligible index always wins

endpackage

// File: rtl/master_switch_rr_if.sv
// Handshake bundle between the stream switch and its environment.
//   sending_flag      transmission enabled
//   packet_sent       current packet complete (one-cycle pulse)
//   ready_to_send     downstream frame builder can accept a stream
//   empty_fifo_flags  bit k = 1: stream k FIFO empty
//   selected_streams  bit k = 1: stream k enabled by the user
//   mux_select        granted stream index (0 when not granted)
//   select_ready      mux_select valid, line open
//   grant_onehot      one-hot of the granted stream (0 when not granted)
//   timeout_flag      one-cycle pulse when a RUN is aborted by timeout
// Modports: slave = switch side, master = environment side.
interface master_switch_rr_if #(
  parameter int unsigned N_STREAMS = 8,
  parameter int unsigned SEL_W     = 3
);
  logic                 sending_flag;
  logic                 packet_sent;
  logic                 ready_to_send;
  logic [N_STREAMS-1:0] empty_fifo_flags;
  logic [N_STREAMS-1:0] selected_streams;
  logic [SEL_W-1:0]     mux_select;
  logic                 select_ready;
  logic [N_STREAMS-1:0] grant_onehot;
  logic                 timeout_flag;

  modport slave (
    input  sending_flag, packet_sent, ready_to_send, empty_fifo_flags, selected_streams,
    output mux_select, select_ready, grant_onehot, timeout_flag
  );

  modport master (
    output sending_flag, packet_sent, ready_to_send, empty_fifo_flags, selected_streams,
    input  mux_select, select_ready, grant_onehot, timeout_flag
  );
endinterface

// File: rtl/rr_priority_encoder.sv
// Single-cycle winner selection over a request vector.
//   req   in  N      request bits
//   ptr   in  SEL_W  round-robin start index (ignored when mode = 1)
//   mode  in  1      0 = round-robin from ptr with wrap, 1 = lowest index wins
//   idx   out SEL_W  winning index (0 when no request)
//   valid out 1      at least one request present
module rr_priority_encoder
  import ms_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [SEL_W-1:0] idx,
  output logic             valid
);

  localparam int unsigned PAD = 32 - SEL_W;

  logic [N-1:0] w_upper;
  logic [N-1:0] w_masked;
  logic [N-1:0] w_src;
  logic         w_found;

  // Round-robin without a scan: requests at or above ptr take precedence;
  // if none, fall back to the whole vector, which gives the wrap to 0.
  always_comb begin
    w_upper = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i >= {{PAD{1'b0}}, ptr}) w_upper[i] = 1'b1;
    end
    w_masked = req & w_upper;
    w_src    = (mode || (w_masked == '0)) ? req : w_masked;

    idx     = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && w_src[i]) begin
        idx     = i[SEL_W-1:0];
        w_found = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/master_switch_rr.sv
// Stream switch: arbitrates between N_STREAMS FIFO-backed datastreams and
// opens the line to one winner per packet.
//   clock   in  rising-edge clock
//   resetn  in  asynchronous reset, active-high (1 = in reset)
//   bus     slave side of master_switch_rr_if (handshake, flags, grant)
// States IDLE -> LOAD -> FIND -> WAIT -> RUN; grant outputs are decoded
// from the registered state so reset removes them without a clock edge.
module master_switch_rr
  import ms_pkg::*;
#(
  parameter int unsigned N_STREAMS      = 8,
  parameter int unsigned SEL_W          = 3,
  parameter int unsigned ARB_MODE       = ARB_RR,
  parameter int unsigned MAX_RUN_CYCLES = 0
) (
  input  logic               clock,
  input  logic               resetn,
  master_switch_rr_if.slave  bus
);

  ms_state_e r_state, w_state_nxt;

  logic [N_STREAMS-1:0] r_mask_q;
  logic [SEL_W-1:0]     r_win_q;
  logic [SEL_W-1:0]     r_ptr_q;

  logic [N_STREAMS-1:0] w_eligible;
  logic [SEL_W-1:0]     w_enc_idx;
  logic                 w_enc_valid;
  logic                 w_mode;
  logic [SEL_W-1:0]     w_win_inc;
  logic                 w_ld_mask;
  logic                 w_ld_win;
  logic                 w_adv_ptr;
  logic                 w_run_start;
  logic                 w_timeout;
  logic                 w_timeout_pulse;
  logic                 w_run;
  logic [N_STREAMS-1:0] w_onehot;

  assign w_mode     = (ARB_MODE == ARB_FIXED);
  assign w_eligible = r_mask_q & ~bus.empty_fifo_flags;
  assign w_win_inc  = (r_win_q == SEL_W'(N_STREAMS - 1)) ? '0 : r_win_q + SEL_W'(1);

  rr_priority_encoder #(
    .N     (N_STREAMS),
    .SEL_W (SEL_W)
  ) u_enc (
    .req   (w_eligible),
    .ptr   (r_ptr_q),
    .mode  (w_mode),
    .idx   (w_enc_idx),
    .valid (w_enc_valid)
  );

  // Run-length watchdog; cleared on entering RUN, saturating.
  generate
    if (MAX_RUN_CYCLES != 0) begin : g_cnt
      localparam int unsigned CW = $clog2(MAX_RUN_CYCLES + 1);
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
          r_cnt <= '0;
        end else if (w_run_start) begin
          r_cnt <= '0;
        end else if ((r_state == ST_RUN) && (r_cnt != CW'(MAX_RUN_CYCLES))) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign w_timeout = (r_state == ST_RUN) && (r_cnt == CW'(MAX_RUN_CYCLES - 1));
    end else begin : g_no_cnt
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      r_mask_q <= '0;
      r_win_q  <= '0;
      r_ptr_q  <= '0;
    end else begin
      if (w_ld_mask) r_mask_q <= bus.selected_streams;
      if (w_ld_win)  r_win_q  <= w_enc_idx;
      if (w_adv_ptr) r_ptr_q  <= w_win_inc;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ld_mask       = 1'b0;
    w_ld_win        = 1'b0;
    w_adv_ptr       = 1'b0;
    w_run_start     = 1'b0;
    w_timeout_pulse = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.sending_flag) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_ld_mask   = 1'b1;
        w_state_nxt = ST_FIND;
      end
      ST_FIND: begin
        if (!bus.sending_flag) begin
          w_state_nxt = ST_IDLE;
        end else if (w_enc_valid) begin
          w_ld_win    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.sending_flag) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.ready_to_send) begin
          w_run_start = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // sending_flag is deliberately ignored here; a completed packet
        // wins over a coincident timeout.
        if (bus.packet_sent) begin
          w_adv_ptr   = !w_mode;
          w_state_nxt = ST_FIND;
        end else if (w_timeout) begin
          w_adv_ptr       = !w_mode;
          w_timeout_pulse = 1'b1;
          w_state_nxt     = ST_FIND;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_onehot = '0;
    w_onehot[r_win_q] = 1'b1;
  end

  assign w_run            = (r_state == ST_RUN);
  assign bus.select_ready = w_run;
  assign bus.mux_select   = w_run ? r_win_q : '0;
  assign bus.grant_onehot = w_run ? w_onehot : '0;
  assign bus.timeout_flag = w_timeout_pulse;

endmodule
